// File: rtl/booth4_seq_mult_ctrl.sv
// Sequential signed NxN multiplier using radix-4 Booth recoding, two multiplier bits per cycle.
// Result and done appear N/2+1 cycles after start is accepted; start is ignored (never queued) while busy.
module booth4_seq_mult_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic [2:0]     digit
);

  localparam int W  = 2 * N;
  localparam int CW = (N > 4) ? $clog2(N / 2) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  mcand;
  logic [W-1:0]  acc;
  logic [N:0]    mreg;
  logic [CW-1:0] cnt;

  logic [2:0]    grp;
  logic [2:0]    rec;
  logic [W-1:0]  sel_mult;
  logic [W-1:0]  pp_signed;
  logic [W-1:0]  pp;
  logic [W-1:0]  sum;
  logic          last;

  // rec = {invert, sel2, sel1}
  always_comb begin
    grp = mreg[2:0];
    rec = 3'b000;
    case (grp)
      3'd1, 3'd2: rec = 3'b001;
      3'd3:       rec = 3'b010;
      3'd4:       rec = 3'b110;
      3'd5, 3'd6: rec = 3'b101;
      default:    rec = 3'b000;
    endcase
  end

  always_comb begin
    digit = (state == RUN) ? rec : 3'b000;
    if (rec[1])
      sel_mult = mcand << 1;
    else if (rec[0])
      sel_mult = mcand;
    else
      sel_mult = '0;
    pp_signed = rec[2] ? (~sel_mult + W'(1)) : sel_mult;
    pp        = pp_signed << {cnt, 1'b0};
    sum       = acc + pp;
    last      = (cnt == CW'(N / 2 - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      mreg    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= {{N{a[N-1]}}, a};
            mreg  <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc  <= sum;
          mreg <= {{2{mreg[N]}}, mreg[N:2]};
          cnt  <= cnt + 1'b1;
          if (last) begin
            product <= sum;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth4_seq_mult_ctrl.sv
// Directed bench for booth4_seq_mult_ctrl at N=8: vector table plus hand-written multi-cycle sequences.
module tb_booth4_seq_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic [2:0]  digit;

  int checks;
  int errors;

  booth4_seq_mult_ctrl #(.N(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .digit   (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] prod;
    logic [11:0] digs;
    bit          chk_digs;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one multiply and checks every cycle of its RUN/DONE window.
  task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp_p,
                         input logic [11:0] exp_d, input bit chk_d, input bit noise);
    int done_seen;
    start = 1'b1;
    a = ta;
    b = tb_v;
    next_cycle();
    start = 1'b0;
    a = ~ta;
    b = tb_v ^ 8'h5A;
    for (int i = 0; i < 4; i++) begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      if (chk_d)
        chk($sformatf("digit%0d", i), 32'(digit), 32'(exp_d[11 - 3 * i -: 3]));
      if (noise && i == 1) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end else begin
        start = 1'b0;
      end
      next_cycle();
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("product", 32'(product), 32'(exp_p));
    chk("done_digit", 32'(digit), 32'd0);
    next_cycle();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("product_hold", 32'(product), 32'(exp_p));
    if (noise) begin
      done_seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (done || busy) done_seen++;
        next_cycle();
      end
      chk("no_second_op", 32'(done_seen), 32'd0);
      chk("product_after_noise", 32'(product), 32'(exp_p));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = 8'h00;
    b      = 8'h00;

    vecs[0] = '{8'd3,   8'd5,   16'h000F, 12'b001_001_000_000, 1'b1};
    vecs[1] = '{8'hF9,  8'd6,   16'hFFD6, 12'b110_010_000_000, 1'b1};
    vecs[2] = '{8'h80,  8'h80,  16'h4000, 12'b000_000_000_110, 1'b1};
    vecs[3] = '{8'h80,  8'h7F,  16'hC080, 12'b000_000_000_000, 1'b0};
    vecs[4] = '{8'h55,  8'h00,  16'h0000, 12'b000_000_000_000, 1'b1};
    vecs[5] = '{8'h7F,  8'h7F,  16'h3F01, 12'b000_000_000_000, 1'b0};
    vecs[6] = '{8'hFF,  8'hFF,  16'h0001, 12'b000_000_000_000, 1'b0};
    vecs[7] = '{8'h01,  8'hFF,  16'hFFFF, 12'b000_000_000_000, 1'b0};
    vecs[8] = '{8'h7F,  8'h80,  16'hC080, 12'b000_000_000_000, 1'b0};

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk("idle_no_start", 32'(busy), 32'd0);

    for (int v = 0; v < 9; v++)
      do_mult(vecs[v].va, vecs[v].vb, vecs[v].prod, vecs[v].digs, vecs[v].chk_digs, 1'b0);

    // Start pulse during RUN must be dropped, not queued.
    do_mult(8'd3, 8'd5, 16'h000F, 12'b001_001_000_000, 1'b1, 1'b1);

    // Start held high: two results separated by a single IDLE cycle.
    start = 1'b1;
    a = 8'd3;
    b = 8'd5;
    next_cycle();
    a = 8'hF9;
    b = 8'd6;
    for (int i = 0; i < 3; i++) next_cycle();
    chk("b2b_done_early", 32'(done), 32'd0);
    next_cycle();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_prod1", 32'(product), 32'h000F);
    next_cycle();
    chk("b2b_idle_gap", 32'(busy), 32'd0);
    next_cycle();
    chk("b2b_busy2", 32'(busy), 32'd1);
    for (int i = 0; i < 4; i++) next_cycle();
    start = 1'b0;
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_prod2", 32'(product), 32'hFFD6);
    next_cycle();
    chk("b2b_end_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    a = 8'hF9;
    b = 8'd6;
    next_cycle();
    start = 1'b0;
    next_cycle();
    chk("pre_rst_digit", 32'(digit), 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_product", 32'(product), 32'd0);
    chk("arst_digit", 32'(digit), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk("post_rst_idle", 32'(busy), 32'd0);
    do_mult(8'd3, 8'd5, 16'h000F, 12'b001_001_000_000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
